// File: rtl/sdram_dl_arbiter.sv
// sdram_dl_arbiter: shares the SDRAM request port between core traffic and byte-packed download writes.
// Optional feature macro SDRAM_DL_CHECKSUM_EN adds dl_checksum / dl_count download statistics.
module sdram_dl_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_CORE_RUN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_busy,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [15:0]       core_wdata,
  input  logic [1:0]        core_be,
  output logic [15:0]       core_rdata,
  output logic              core_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
`ifdef SDRAM_DL_CHECKSUM_EN
  ,
  output logic [15:0]       dl_checksum,
  output logic [ADDR_W-1:0] dl_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_CORE_RUN + 1);
  localparam int WA_W  = ADDR_W - 1;

  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  ALMOST_CNT = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(MAX_CORE_RUN);
  localparam logic [ADDR_W-1:0] WORD_MASK  = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, CORE, DL} state_t;

  typedef struct packed {
    logic [WA_W-1:0] waddr;
    logic [15:0]     data;
    logic [1:0]      be;
  } dl_word_t;

  state_t state_q, state_d;

  logic            dl_active_q;
  logic            pk_valid;
  logic [WA_W-1:0] pk_waddr;
  logic [7:0]      pk_data;

  dl_word_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [RUN_W-1:0] run_q;

  logic     fifo_full, fifo_empty;
  logic     accept, byte_odd, same_word, dl_fall;
  logic     push, pop, pk_load, pk_clear;
  dl_word_t push_word, head;
  logic     mem_ack_g, force_dl;
  logic     issue_core, issue_dl, core_done, dl_done;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // Busy one slot early when a held byte could still need the last slot.
  assign dl_busy    = fifo_full || ((count == ALMOST_CNT) && pk_valid);
  assign accept     = dl_wr && !dl_busy;
  assign byte_odd   = dl_addr[0];
  assign same_word  = (pk_waddr == dl_addr[ADDR_W-1:1]);
  assign dl_fall    = dl_active_q && !dl_active;

  assign mem_ack_g  = mem_ack && mem_req;
  assign force_dl   = (run_q == RUN_MAX) && !fifo_empty;
  assign pop        = dl_done;

  // ---------------------------------------------------------------- packer
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    pk_load   = 1'b0;
    pk_clear  = 1'b0;
    if (accept) begin
      if (byte_odd) begin
        push = 1'b1;
        if (pk_valid && same_word) begin
          push_word.waddr = pk_waddr;
          push_word.data  = {dl_data, pk_data};
          push_word.be    = 2'b11;
          pk_clear        = 1'b1;
        end else begin
          push_word.waddr = dl_addr[ADDR_W-1:1];
          push_word.data  = {dl_data, 8'h00};
          push_word.be    = 2'b10;
        end
      end else begin
        pk_load = 1'b1;
        if (pk_valid && !same_word) begin
          push            = 1'b1;
          push_word.waddr = pk_waddr;
          push_word.data  = {8'h00, pk_data};
          push_word.be    = 2'b01;
        end
      end
    end else if (dl_fall && pk_valid && !fifo_full) begin
      push            = 1'b1;
      push_word.waddr = pk_waddr;
      push_word.data  = {8'h00, pk_data};
      push_word.be    = 2'b01;
      pk_clear        = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_active_q <= 1'b0;
      pk_valid    <= 1'b0;
      pk_waddr    <= '0;
      pk_data     <= '0;
    end else begin
      dl_active_q <= dl_active;
      if (pk_load) begin
        pk_valid <= 1'b1;
        pk_waddr <= dl_addr[ADDR_W-1:1];
        pk_data  <= dl_data;
      end else if (pk_clear) begin
        pk_valid <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  // NOTE: the storage array has no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // -------------------------------------------------------------- arbiter
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (core_req && !force_dl) state_d = CORE;
        else if (!fifo_empty)      state_d = DL;
      end
      CORE, DL: if (mem_ack_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_core = 1'b0;
    issue_dl   = 1'b0;
    core_done  = 1'b0;
    dl_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_core = (state_d == CORE);
        issue_dl   = (state_d == DL);
      end
      CORE:    core_done = mem_ack_g;
      DL:      dl_done   = mem_ack_g;
      default: ;
    endcase
  end

  // Request fields are captured at grant time so they stay stable until mem_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      core_ack   <= 1'b0;
      core_rdata <= '0;
    end else begin
      core_ack <= core_done;
      if (core_done) core_rdata <= mem_rdata;
      if (issue_core) begin
        mem_we    <= core_we;
        mem_addr  <= core_addr & WORD_MASK;
        mem_wdata <= core_wdata;
        mem_be    <= core_be;
      end else if (issue_dl) begin
        mem_we    <= 1'b1;
        mem_addr  <= {head.waddr, 1'b0};
        mem_wdata <= head.data;
        mem_be    <= head.be;
      end
      if (mem_ack_g)              mem_req <= 1'b0;
      else if (state_q != IDLE)   mem_req <= 1'b1;
    end
  end

  // Starvation guard: counts core completions while download words wait.
  always_ff @(posedge clk) begin
    if (reset)                              run_q <= '0;
    else if (fifo_empty || issue_dl)        run_q <= '0;
    else if (core_done && run_q != RUN_MAX) run_q <= run_q + RUN_W'(1);
  end

`ifdef SDRAM_DL_CHECKSUM_EN
  logic              dl_rise;
  logic [15:0]       sum_q;
  logic [ADDR_W-1:0] cnt_q;

  assign dl_rise = dl_active && !dl_active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (dl_rise) begin
      sum_q <= accept ? {8'h00, dl_data} : 16'h0000;
      cnt_q <= accept ? ADDR_W'(1) : '0;
    end else if (dl_active && accept) begin
      sum_q <= sum_q + {8'h00, dl_data};
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  assign dl_checksum = sum_q;
  assign dl_count    = cnt_q;
`endif

endmodule

// File: tb/tb_sdram_dl_arbiter.sv
// Self-checking bench for sdram_dl_arbiter: packing vectors, latency, starvation guard, FIFO full, reset.
module tb_sdram_dl_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr;
  logic [23:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_busy;
  logic        core_req, core_we;
  logic [23:0] core_addr;
  logic [15:0] core_wdata;
  logic [1:0]  core_be;
  logic [15:0] core_rdata;
  logic        core_ack;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack   = 1'b0;
`ifdef SDRAM_DL_CHECKSUM_EN
  logic [15:0] dl_checksum;
  logic [23:0] dl_count;
`endif

  always #5 clk = ~clk;

  sdram_dl_arbiter #(.ADDR_W(24), .FIFO_DEPTH(4), .MAX_CORE_RUN(8)) dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_be(core_be), .core_rdata(core_rdata), .core_ack(core_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef SDRAM_DL_CHECKSUM_EN
    , .dl_checksum(dl_checksum), .dl_count(dl_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // SDRAM model: acks 3 cycles after mem_req rises, while acks < ack_limit.
  int ack_limit = 0;
  int ack_wait  = 0;
  int acks      = 0;
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req && acks < ack_limit) begin
      if (ack_wait == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hC000 + 16'(acks);
        acks++;
        ack_wait  = 0;
      end else begin
        ack_wait++;
      end
    end else begin
      ack_wait = 0;
    end
  end

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } grant_t;

  grant_t grants[$];
  int     core_acks = 0;
  always @(negedge clk) begin
    grant_t g;
    if (mem_req && mem_ack) begin
      g.we = mem_we; g.addr = mem_addr; g.wdata = mem_wdata; g.be = mem_be;
      grants.push_back(g);
    end
    if (core_ack) core_acks++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [23:0] a, input logic [7:0] d);
    int n = 0;
    while (dl_busy && n < 300) begin tick(); n++; end
    if (dl_busy) check("dl_busy_timeout", 32'(dl_busy), 0);
    dl_addr = a; dl_data = d; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic wait_grants(input int target, input string name);
    int n = 0;
    while (grants.size() < target && n < 3000) begin tick(); n++; end
    if (grants.size() < target) check(name, grants.size(), target);
  endtask

  task automatic wait_mem_ack(input string name);
    int n = 0;
    while (!mem_ack && n < 200) begin tick(); n++; end
    if (!mem_ack) check(name, 32'(mem_ack), 1);
  endtask

  task automatic flush_dl();
    dl_active = 1'b0; tick(); tick();
    dl_active = 1'b1; tick();
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
    bit          flush;
    bit          exp_push;
    logic [23:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_be;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base, cbase, n, n_exp, k, ncore;
    logic [15:0] exp_rdata;

    vecs[0] = '{24'h000100, 8'h11, 1'b0, 1'b0, 24'h000000, 16'h0000, 2'b00};
    vecs[1] = '{24'h000101, 8'h22, 1'b0, 1'b1, 24'h000100, 16'h2211, 2'b11};
    vecs[2] = '{24'h000205, 8'h33, 1'b1, 1'b1, 24'h000204, 16'h3300, 2'b10};
    vecs[3] = '{24'h000300, 8'h44, 1'b1, 1'b1, 24'h000300, 16'h0044, 2'b01};
    vecs[4] = '{24'h000400, 8'h55, 1'b0, 1'b0, 24'h000000, 16'h0000, 2'b00};
    vecs[5] = '{24'h000502, 8'h66, 1'b0, 1'b1, 24'h000400, 16'h0055, 2'b01};
    vecs[6] = '{24'h000601, 8'h77, 1'b0, 1'b1, 24'h000600, 16'h7700, 2'b10};
    vecs[7] = '{24'h000503, 8'h88, 1'b0, 1'b1, 24'h000502, 16'h8866, 2'b11};
    vecs[8] = '{24'h0007FE, 8'h99, 1'b1, 1'b1, 24'h0007FE, 16'h0099, 2'b01};
    vecs[9] = '{24'hFFFFFF, 8'hAA, 1'b0, 1'b1, 24'hFFFFFE, 16'hAA00, 2'b10};

    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_core_ack", 32'(core_ack), 0);
    check("rst_dl_busy", 32'(dl_busy), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_core_rdata", core_rdata, 0);
    reset = 1'b0; dl_active = 1'b1;
    tick();

    // Idle core read: request latency, ack latency, read data return.
    ack_limit = 1_000_000;
    core_we = 1'b0; core_addr = 24'h123457; core_be = 2'b11; core_wdata = 16'hBEEF;
    core_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!mem_req && n < 20);
    check("req_latency", n, 2);
    check("core_mem_addr", mem_addr, 24'h123456);
    check("core_mem_we", 32'(mem_we), 0);
    exp_rdata = 16'hC000 + 16'(acks);
    wait_mem_ack("core_ack_wait");
    check("core_ack_early", 32'(core_ack), 0);
    tick();
    check("core_ack_pulse", 32'(core_ack), 1);
    check("core_rdata", core_rdata, exp_rdata);
    check("mem_req_drop", 32'(mem_req), 0);
    core_req = 1'b0;
    tick();
    check("core_ack_one_cycle", 32'(core_ack), 0);
    tick(); tick(); tick();
    check("no_regrant", 32'(mem_req), 0);

    // Table-driven packing vectors; every resulting FIFO word becomes a DL write in order.
    base = grants.size();
    n_exp = 0;
    foreach (vecs[i]) if (vecs[i].exp_push) n_exp++;
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].addr, vecs[i].data);
      tick();
      if (vecs[i].flush) flush_dl();
    end
    wait_grants(base + n_exp, "pack_grants_timeout");
    repeat (10) tick();
    check("pack_grant_count", grants.size() - base, n_exp);
    k = base;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_push && k < grants.size()) begin
        check($sformatf("pack%0d_we", i), 32'(grants[k].we), 1);
        check($sformatf("pack%0d_addr", i), grants[k].addr, vecs[i].exp_addr);
        check($sformatf("pack%0d_be", i), grants[k].be, vecs[i].exp_be);
        check($sformatf("pack%0d_wdata", i), grants[k].wdata & lane_mask(vecs[i].exp_be),
              vecs[i].exp_wdata & lane_mask(vecs[i].exp_be));
        k++;
      end
    end

    // FIFO full with mem_ack held low; dropped byte; one ack frees a slot.
    ack_limit = acks;
    base = grants.size();
    for (int i = 0; i < 3; i++) begin
      send_byte(24'h001000 + 24'(2*i), 8'h10 + 8'(i));
      send_byte(24'h001001 + 24'(2*i), 8'h20 + 8'(i));
      check($sformatf("busy_after_word%0d", i + 1), 32'(dl_busy), 0);
    end
    send_byte(24'h001007, 8'h77);
    check("busy_after_4_words", 32'(dl_busy), 1);
    dl_addr = 24'h001100; dl_data = 8'hEE; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    tick();
    check("busy_held", 32'(dl_busy), 1);
    ack_limit = acks + 1;
    wait_mem_ack("busy_ack_wait");
    tick();
    check("busy_clear_after_ack", 32'(dl_busy), 0);
    send_byte(24'h001200, 8'h88);
    check("busy_one_slot_held_byte", 32'(dl_busy), 1);
    flush_dl();
    check("busy_full_after_flush", 32'(dl_busy), 1);
    ack_limit = 1_000_000;
    wait_grants(base + 5, "full_grants_timeout");
    repeat (10) tick();
    check("full_grant_count", grants.size() - base, 5);
    if (grants.size() >= base + 5) begin
      check("full_w0_addr", grants[base].addr, 24'h001000);
      check("full_w0_wdata", grants[base].wdata, 16'h2010);
      check("full_w2_addr", grants[base+2].addr, 24'h001004);
      check("full_w3_be", grants[base+3].be, 2'b10);
      check("full_w3_hi", grants[base+3].wdata[15:8], 8'h77);
      check("full_w4_addr", grants[base+4].addr, 24'h001200);
      check("full_w4_lo", grants[base+4].wdata[7:0], 8'h88);
    end

    // Starvation guard: core_req held with two words queued.
    base = grants.size(); cbase = core_acks;
    core_we = 1'b0; core_addr = 24'h008000; core_be = 2'b11;
    core_req = 1'b1;
    send_byte(24'h002000, 8'h01);
    send_byte(24'h002001, 8'h02);
    send_byte(24'h002002, 8'h03);
    send_byte(24'h002003, 8'h04);
    wait_grants(base + 20, "run_grants_timeout");
    n = 0;
    while (!core_ack && n < 100) begin tick(); n++; end
    core_req = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 20; i++) begin
      if (base + i < grants.size())
        check($sformatf("run_grant%0d_is_dl", i), 32'(grants[base+i].we), (i == 8 || i == 17) ? 1 : 0);
    end
    if (grants.size() >= base + 18) begin
      check("run_dl0_addr", grants[base+8].addr, 24'h002000);
      check("run_dl0_wdata", grants[base+8].wdata, 16'h0201);
      check("run_dl1_addr", grants[base+17].addr, 24'h002002);
    end
    ncore = 0;
    for (int i = base; i < grants.size(); i++) if (!grants[i].we) ncore++;
    check("run_core_ack_count", core_acks - cbase, ncore);

    // Reset during a core grant discards the grant, the FIFO word and the held byte.
    ack_limit = acks;
    core_addr = 24'h00A000; core_req = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    check("rstmid_granted", 32'(mem_req), 1);
    send_byte(24'h000200, 8'hAB);
    send_byte(24'h000201, 8'hCD);
    send_byte(24'h000300, 8'hEF);
    reset = 1'b1;
    tick();
    check("rstmid_mem_req", 32'(mem_req), 0);
    check("rstmid_core_ack", 32'(core_ack), 0);
    check("rstmid_dl_busy", 32'(dl_busy), 0);
    tick();
    reset = 1'b0; core_req = 1'b0; ack_limit = 1_000_000;
    base = grants.size();
    repeat (20) tick();
    check("rstmid_no_grants", grants.size() - base, 0);
    check("rstmid_idle", 32'(mem_req), 0);

`ifdef SDRAM_DL_CHECKSUM_EN
    dl_active = 1'b0; tick(); tick();
    dl_active = 1'b1;
    for (int i = 0; i < 257; i++) send_byte(24'h003000 + 24'(i), 8'hFF);
    tick();
    dl_active = 1'b0; tick(); tick();
    check("ck_count", dl_count, 257);
    check("ck_sum", dl_checksum, 16'hFFFF);
    send_byte(24'h004000, 8'h12);
    check("ck_frozen", dl_checksum, 16'hFFFF);
    repeat (200) tick();
`endif

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
